// File: rtl/draw_snake_body.sv
// draw_snake_body: snake head/tail renderer with internal body storage on a 2-stage VGA pixel pipeline
module draw_snake_body #(
  parameter int MAX_LEN = 16,
  parameter int X_W = 7,
  parameter int Y_W = 6,
  parameter int GRID = 10,
  parameter logic [11:0] HEAD_COLOUR = 12'h5c0,
  parameter logic [11:0] TAIL_COLOUR = 12'h5d1,
  parameter bit GRADIENT = 1,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [10:0]    hcount_in,
  input  logic           hsync_in,
  input  logic           hblnk_in,
  input  logic [10:0]    vcount_in,
  input  logic           vsync_in,
  input  logic           vblnk_in,
  input  logic [11:0]    rgb_in,
  input  logic           move,
  input  logic           grow,
  input  logic           clear,
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  output logic [10:0]    hcount_out,
  output logic           hsync_out,
  output logic           hblnk_out,
  output logic [10:0]    vcount_out,
  output logic           vsync_out,
  output logic           vblnk_out,
  output logic [11:0]    rgb_out,
  output logic [LW-1:0]  length_out,
  output logic           self_hit
);
  localparam int SW = $clog2(GRID);
  localparam logic [SW-1:0] G_LAST = SW'(GRID - 1);
  logic [10:0] h_prev, v_prev;
  logic [SW-1:0] sub_x, sub_y, sub_x_n, sub_y_n;
  logic [X_W-1:0] cell_x, cell_x_n, hd_x, cx1;
  logic [Y_W-1:0] cell_y, cell_y_n, hd_y, cy1;
  logic [X_W-1:0] sx [MAX_LEN];
  logic [Y_W-1:0] sy [MAX_LEN];
  logic [LW-1:0] len, seg_idx;
  logic h_step, v_step, chk_q, seg_hit, body_hit, head_hit;
  logic [10:0] h1, v1;
  logic hs1, hb1, vs1, vb1;
  logic [11:0] rgb1, seg_col, rgb_n;
  // next cell values belong to the pixel on the inputs this cycle
  assign h_step = hcount_in != h_prev;
  assign v_step = vcount_in != v_prev;
  assign sub_x_n = hcount_in == '0 ? '0 : !h_step ? sub_x : sub_x == G_LAST ? '0 : sub_x + 1'b1;
  assign sub_y_n = vcount_in == '0 ? '0 : !v_step ? sub_y : sub_y == G_LAST ? '0 : sub_y + 1'b1;
  assign cell_x_n = hcount_in == '0 ? '0 : (h_step && sub_x == G_LAST && cell_x != '1) ? cell_x + 1'b1 : cell_x;
  assign cell_y_n = vcount_in == '0 ? '0 : (v_step && sub_y == G_LAST && cell_y != '1) ? cell_y + 1'b1 : cell_y;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {h_prev, v_prev, sub_x, sub_y, cell_x, cell_y} <= '0;
      {h1, hs1, hb1, v1, vs1, vb1, rgb1, cx1, cy1} <= '0;
    end else begin
      {h_prev, v_prev, sub_x, sub_y, cell_x, cell_y} <= {hcount_in, vcount_in, sub_x_n, sub_y_n, cell_x_n, cell_y_n};
      {h1, hs1, hb1, v1, vs1, vb1, rgb1, cx1, cy1} <= {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in, cell_x_n, cell_y_n};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {hd_x, hd_y, len} <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else if (clear) begin
      {hd_x, hd_y, len} <= {head_x, head_y, {LW{1'b0}}};
    end else if (move) begin
      sx[0] <= hd_x;
      sy[0] <= hd_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        sx[i] <= sx[i-1];
        sy[i] <= sy[i-1];
      end
      {hd_x, hd_y} <= {head_x, head_y};
      if (grow && len != LW'(MAX_LEN)) len <= len + 1'b1;
    end
  end
  // collision is evaluated one cycle after a move, against the shifted body
  always_ff @(posedge clk) begin
    if (!reset_n) {chk_q, self_hit} <= '0;
    else begin
      chk_q <= move && !clear;
      self_hit <= clear ? 1'b0 : self_hit | (chk_q & body_hit);
    end
  end
  // descending scan so the lowest matching index wins
  always_comb begin
    seg_hit = 1'b0;
    seg_idx = '0;
    body_hit = 1'b0;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (LW'(i) < len && sx[i] == cx1 && sy[i] == cy1) begin
        seg_hit = 1'b1;
        seg_idx = LW'(i);
      end
      body_hit = body_hit | (LW'(i) < len && sx[i] == hd_x && sy[i] == hd_y);
    end
  end
  assign head_hit = cx1 == hd_x && cy1 == hd_y;
  assign seg_col = GRADIENT ? TAIL_COLOUR + 12'(seg_idx) : TAIL_COLOUR;
  assign rgb_n = (hb1 | vb1) ? rgb1 : head_hit ? HEAD_COLOUR : seg_hit ? seg_col : rgb1;
  always_ff @(posedge clk) begin
    if (!reset_n) {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out} <= '0;
    else {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out} <= {h1, hs1, hb1, v1, vs1, vb1, rgb_n};
  end
  assign length_out = len;
endmodule
